// File: rtl/multi_dataflow_mmult_opt_mdc_package.sv
// ============================================================================
// multi_dataflow_mmult_opt_mdc_package : shared types for the mmult engine
// Rev 1.0
// ============================================================================
`default_nettype none

package multi_dataflow_mmult_opt_mdc_package;

  localparam int unsigned ENG_CNT_WIDTH = 16;

  typedef struct packed {
    logic                     start;
    logic [ENG_CNT_WIDTH-1:0] len;
    logic [ENG_CNT_WIDTH-1:0] nb_out;
  } ctrl_engine_mmult_opt_mdc_t;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [ENG_CNT_WIDTH-1:0] res_cnt;
  } flags_engine_mmult_opt_mdc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } engine_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
// ============================================================================
// hwpe_stream_intf_stream : valid/ready stream with data and byte strobes
// Rev 1.0
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

`default_nettype wire

// File: rtl/multi_dataflow_mmult_opt_mdc_mac.sv
// ============================================================================
// multi_dataflow_mmult_opt_mdc_mac : registered signed MAC with wrapping add
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_dataflow_mmult_opt_mdc_mac #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  logic signed [DATA_WIDTH-1:0] prod;
  logic        [DATA_WIDTH-1:0] acc_q;
  logic        [DATA_WIDTH-1:0] acc_d;

  // Only the low DATA_WIDTH bits of the signed product are ever needed.
  assign prod = $signed(a_i) * $signed(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/multi_dataflow_mmult_opt_mdc_engine.sv
// ============================================================================
// multi_dataflow_mmult_opt_mdc_engine : joins in1/in2, emits int32 dot products
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_dataflow_mmult_opt_mdc_engine
  import multi_dataflow_mmult_opt_mdc_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = ENG_CNT_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        clear_i,
  hwpe_stream_intf_stream.sink        in1,
  hwpe_stream_intf_stream.sink        in2,
  hwpe_stream_intf_stream.source      out_r,
  input  ctrl_engine_mmult_opt_mdc_t  ctrl_i,
  output flags_engine_mmult_opt_mdc_t flags_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  engine_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  nb_out_q, nb_out_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
  logic                  acc_clr;
  logic                  fire;
  logic [DATA_WIDTH-1:0] acc;

  // Join: a beat is taken only when both operands are present together.
  assign fire = (state_q == ACC) & enable_i & ~clear_i & in1.valid & in2.valid;

  multi_dataflow_mmult_opt_mdc_mac #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (acc_clr),
    .en_i  (fire),
    .a_i   (in1.data),
    .b_i   (in2.data),
    .acc_o (acc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      nb_out_q   <= '0;
      beat_cnt_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      len_q      <= len_d;
      nb_out_q   <= nb_out_d;
      beat_cnt_q <= beat_cnt_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    nb_out_d   = nb_out_q;
    beat_cnt_d = beat_cnt_q;
    res_cnt_d  = res_cnt_q;
    acc_clr    = 1'b0;
    if (clear_i) begin
      state_d    = IDLE;
      len_d      = '0;
      nb_out_d   = '0;
      beat_cnt_d = '0;
      res_cnt_d  = '0;
      acc_clr    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i && ctrl_i.start) begin
            len_d      = ctrl_i.len;
            nb_out_d   = ctrl_i.nb_out;
            beat_cnt_d = '0;
            res_cnt_d  = '0;
            acc_clr    = 1'b1;
            if ((ctrl_i.len == '0) || (ctrl_i.nb_out == '0)) begin
              state_d = DONE;
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          if (fire) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
            if (beat_cnt_q == len_q - CNT_ONE) begin
              state_d = EMIT;
            end
          end
        end
        EMIT: begin
          if (enable_i && out_r.ready) begin
            res_cnt_d = res_cnt_q + CNT_ONE;
            if (res_cnt_q == nb_out_q - CNT_ONE) begin
              state_d = DONE;
            end else begin
              state_d    = ACC;
              beat_cnt_d = '0;
              acc_clr    = 1'b1;
            end
          end
        end
        DONE: begin
          // Leaves unconditionally so the done pulse is always a single cycle.
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    flags_o         = '0;
    flags_o.busy    = (state_q != IDLE);
    flags_o.done    = (state_q == DONE);
    flags_o.res_cnt = res_cnt_q;
  end

  assign in1.ready   = fire;
  assign in2.ready   = fire;
  assign out_r.valid = (state_q == EMIT);
  assign out_r.data  = acc;
  assign out_r.strb  = '1;

endmodule

`default_nettype wire

// File: tb/tb_multi_dataflow_mmult_opt_mdc_engine.sv
// ============================================================================
// tb_multi_dataflow_mmult_opt_mdc_engine : directed self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_dataflow_mmult_opt_mdc_engine;
  import multi_dataflow_mmult_opt_mdc_package::*;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic clear;
  ctrl_engine_mmult_opt_mdc_t  ctrl;
  flags_engine_mmult_opt_mdc_t flags;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in1_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in2_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_if ();

  multi_dataflow_mmult_opt_mdc_engine #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .clear_i  (clear),
    .in1      (in1_if),
    .in2      (in2_if),
    .out_r    (out_if),
    .ctrl_i   (ctrl),
    .flags_o  (flags)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int f1_cnt = 0;
  int f2_cnt = 0;
  int lone_cnt = 0;
  int ovld_cnt = 0;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (flags.done) done_cnt++;
    if (in1_if.valid && in1_if.ready) f1_cnt++;
    if (in2_if.valid && in2_if.ready) f2_cnt++;
    if (in1_if.ready && !in2_if.valid) lone_cnt++;
    if (out_if.valid) ovld_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [15:0] len, input logic [15:0] nb);
    ctrl.start  = 1'b1;
    ctrl.len    = len;
    ctrl.nb_out = nb;
    tick();
    ctrl.start  = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] b, input string tag);
    bit ok = 1'b0;
    in1_if.valid = 1'b1;
    in1_if.data  = a;
    in2_if.valid = 1'b1;
    in2_if.data  = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = in1_if.ready && in2_if.ready;
    end
    tick();
    in1_if.valid = 1'b0;
    in2_if.valid = 1'b0;
    chk({tag, "_fire"}, 64'(ok), 64'd1);
  endtask

  task automatic pop(input logic [31:0] exp, input string tag);
    bit          seen = 1'b0;
    logic [31:0] d    = '0;
    out_if.ready = 1'b1;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (out_if.valid) begin
        seen = 1'b1;
        d    = out_if.data;
      end
    end
    tick();
    out_if.ready = 1'b0;
    chk({tag, "_vld"}, 64'(seen), 64'd1);
    chk({tag, "_data"}, 64'(d), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, b1, b2, bl, bo, k;
    bit stable, fired;
    logic [31:0] ta [4];
    logic [31:0] tb [4];

    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    ctrl = '0;
    in1_if.valid = 1'b0; in1_if.data = '0; in1_if.strb = '0;
    in2_if.valid = 1'b0; in2_if.data = '0; in2_if.strb = '0;
    out_if.ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", 64'(out_if.valid), 64'd0);
    chk("rst_data",  64'(out_if.data), 64'd0);
    chk("rst_strb",  64'(out_if.strb), 64'hF);
    chk("rst_rdy",   64'({in1_if.ready, in2_if.ready}), 64'd0);
    chk("rst_busy",  64'(flags.busy), 64'd0);
    chk("rst_done",  64'(flags.done), 64'd0);
    chk("rst_res",   64'(flags.res_cnt), 64'd0);

    // 1: len=3, nb_out=1 -> 1*4+2*5+3*6 = 32
    d0 = done_cnt;
    start_op(16'd3, 16'd1);
    chk("t1_busy", 64'(flags.busy), 64'd1);
    push_beat(32'd1, 32'd4, "t1_b0");
    push_beat(32'd2, 32'd5, "t1_b1");
    push_beat(32'd3, 32'd6, "t1_b2");
    chk("t1_lat", 64'(out_if.valid), 64'd1);
    pop(32'd32, "t1_out");
    chk("t1_done_hi", 64'(flags.done), 64'd1);
    tick();
    chk("t1_done_lo", 64'(flags.done), 64'd0);
    chk("t1_idle", 64'(flags.busy), 64'd0);
    chk("t1_res", 64'(flags.res_cnt), 64'd1);
    chk("t1_ndone", 64'(done_cnt - d0), 64'd1);

    // 2: len=2, nb_out=2 -> -3+7 = 4, then 2*0x7FFFFFFF+4 wraps to 2
    d0 = done_cnt;
    start_op(16'd2, 16'd2);
    chk("t2_res0", 64'(flags.res_cnt), 64'd0);
    push_beat(32'hFFFF_FFFF, 32'd3, "t2_b0");
    push_beat(32'd7, 32'd1, "t2_b1");
    pop(32'd4, "t2_out0");
    chk("t2_res1", 64'(flags.res_cnt), 64'd1);
    chk("t2_acc_clr", 64'(out_if.data), 64'd0);
    push_beat(32'd2, 32'h7FFF_FFFF, "t2_b2");
    push_beat(32'd2, 32'd2, "t2_b3");
    pop(32'd2, "t2_out1");
    chk("t2_done", 64'(flags.done), 64'd1);
    tick();
    chk("t2_res2", 64'(flags.res_cnt), 64'd2);
    chk("t2_ndone", 64'(done_cnt - d0), 64'd1);

    // 3: in1 valid every cycle, in2 every 3rd -> 10+40+90+160 = 300
    ta[0] = 32'd1;  ta[1] = 32'd2;  ta[2] = 32'd3;  ta[3] = 32'd4;
    tb[0] = 32'd10; tb[1] = 32'd20; tb[2] = 32'd30; tb[3] = 32'd40;
    b1 = f1_cnt; b2 = f2_cnt; bl = lone_cnt;
    start_op(16'd4, 16'd1);
    k = 0;
    for (int c = 0; c < 100 && k < 4; c++) begin
      in1_if.valid = 1'b1;
      in1_if.data  = ta[k];
      in2_if.valid = ((c % 3) == 2);
      in2_if.data  = tb[k];
      @(negedge clk);
      fired = in1_if.valid && in1_if.ready;
      tick();
      if (fired) k++;
    end
    in1_if.valid = 1'b0;
    in2_if.valid = 1'b0;
    chk("t3_beats", 64'(k), 64'd4);
    chk("t3_lat", 64'(out_if.valid), 64'd1);
    chk("t3_f1", 64'(f1_cnt - b1), 64'd4);
    chk("t3_f2", 64'(f2_cnt - b2), 64'd4);
    chk("t3_lone", 64'(lone_cnt - bl), 64'd0);
    pop(32'd300, "t3_out");
    tick();

    // 4: back-pressure in EMIT, then enable_i=0 freezes the handshake
    b1 = f1_cnt;
    start_op(16'd1, 16'd1);
    push_beat(32'hFFFF_FFFB, 32'd6, "t4_b0");
    in1_if.valid = 1'b1; in1_if.data = 32'd99;
    in2_if.valid = 1'b1; in2_if.data = 32'd99;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_if.valid || out_if.data !== 32'hFFFF_FFE2 || in1_if.ready || in2_if.ready)
        stable = 1'b0;
    end
    tick();
    chk("t4_hold", 64'(stable), 64'd1);
    enable = 1'b0;
    out_if.ready = 1'b1;
    repeat (3) tick();
    chk("t4_en_vld", 64'(out_if.valid), 64'd1);
    chk("t4_en_res", 64'(flags.res_cnt), 64'd0);
    enable = 1'b1;
    tick();
    out_if.ready = 1'b0;
    in1_if.valid = 1'b0;
    in2_if.valid = 1'b0;
    chk("t4_done", 64'(flags.done), 64'd1);
    chk("t4_res", 64'(flags.res_cnt), 64'd1);
    chk("t4_f1", 64'(f1_cnt - b1), 64'd1);
    tick();

    // 5: degenerate lengths, then start while busy is ignored
    d0 = done_cnt; bo = ovld_cnt;
    start_op(16'd0, 16'd5);
    chk("t5a_done", 64'(flags.done), 64'd1);
    tick();
    chk("t5a_idle", 64'({flags.busy, flags.done}), 64'd0);
    start_op(16'd4, 16'd0);
    chk("t5b_done", 64'(flags.done), 64'd1);
    tick();
    chk("t5b_idle", 64'({flags.busy, flags.done}), 64'd0);
    chk("t5_ndone", 64'(done_cnt - d0), 64'd2);
    chk("t5_nout", 64'(ovld_cnt - bo), 64'd0);
    d0 = done_cnt;
    start_op(16'd2, 16'd1);
    start_op(16'd5, 16'd3);
    push_beat(32'd3, 32'd5, "t5c_b0");
    push_beat(32'd4, 32'd6, "t5c_b1");
    pop(32'd39, "t5c_out");
    tick();
    chk("t5c_idle", 64'(flags.busy), 64'd0);
    chk("t5c_res", 64'(flags.res_cnt), 64'd1);
    chk("t5c_ndone", 64'(done_cnt - d0), 64'd1);

    // 6: soft clear mid-ACC, async reset mid-EMIT, then a clean run
    d0 = done_cnt;
    start_op(16'd3, 16'd1);
    push_beat(32'd5, 32'd5, "t6_b0");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_busy", 64'(flags.busy), 64'd0);
    chk("t6_clr_data", 64'(out_if.data), 64'd0);
    chk("t6_clr_vld", 64'(out_if.valid), 64'd0);
    start_op(16'd2, 16'd1);
    push_beat(32'd1, 32'd1, "t6_b1");
    push_beat(32'd1, 32'd1, "t6_b2");
    chk("t6_emit", 64'(out_if.valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_vld", 64'(out_if.valid), 64'd0);
    chk("t6_rst_busy", 64'(flags.busy), 64'd0);
    chk("t6_rst_data", 64'(out_if.data), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_nodone", 64'(done_cnt - d0), 64'd0);
    start_op(16'd2, 16'd1);
    push_beat(32'd2, 32'd4, "t6_b3");
    push_beat(32'd3, 32'd5, "t6_b4");
    pop(32'd23, "t6_out");
    tick();
    chk("t6_res", 64'(flags.res_cnt), 64'd1);
    chk("t6_ndone", 64'(done_cnt - d0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
